// File: rtl/adc_window_peak_detector.sv
// Windowed peak-magnitude detector for packed multi-lane ADC beats.
// Optional threshold compare is compiled in when PEAK_THRESHOLD_EN is defined.

module adc_window_peak_detector #(
    parameter int unsigned SAMPLE_WIDTH     = 16,
    parameter int unsigned SAMPLES_PER_WORD = 8,
    parameter int unsigned WIN_WIDTH        = 8,
    parameter int unsigned BASE_ADDR        = 2,
    localparam int unsigned LANE_BITS       = $clog2(SAMPLES_PER_WORD),
    localparam int unsigned POS_WIDTH       = WIN_WIDTH + LANE_BITS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [31:0]                              gpio_in,
    input  logic [SAMPLE_WIDTH*SAMPLES_PER_WORD-1:0] s_axis_tdata,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic                                     run,
    output logic [SAMPLE_WIDTH-1:0]                  peak_out,
    output logic [SAMPLE_WIDTH-1:0]                  peak_mag,
    output logic [POS_WIDTH-1:0]                     peak_pos,
    output logic                                     peak_valid,
    output logic                                     peak_over_thresh,
    output logic                                     busy
);

    localparam int unsigned DATA_W = SAMPLE_WIDTH * SAMPLES_PER_WORD;
    localparam int unsigned NODES  = 2 * SAMPLES_PER_WORD - 1;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    function automatic logic [SAMPLE_WIDTH-1:0] abs_mag(input logic [SAMPLE_WIDTH-1:0] x);
        return x[SAMPLE_WIDTH-1] ? -x : x;
    endfunction

    // ---------------------------------------------------------------- config bus
    logic [15:0]          gpio_addr;
    logic [7:0]           gpio_data;
    logic                 gpio_wclk;
    logic                 unused_gpio;
    logic                 wclk_q, wclk_d;
    logic                 wr_stb;
    logic [WIN_WIDTH-1:0] win_len_q, win_len_d;
    logic                 cont_q, cont_d;

    assign gpio_addr   = gpio_in[15:0];
    assign gpio_data   = gpio_in[23:16];
    assign gpio_wclk   = gpio_in[24];
    assign unused_gpio = ^gpio_in[31:25];

    always_comb begin
        wclk_d    = gpio_wclk;
        wr_stb    = gpio_wclk & ~wclk_q;
        win_len_d = win_len_q;
        cont_d    = cont_q;
        if (wr_stb && gpio_addr == 16'(BASE_ADDR)) begin
            win_len_d = WIN_WIDTH'(gpio_data);
        end
        if (wr_stb && gpio_addr == 16'(BASE_ADDR + 1)) begin
            cont_d = gpio_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wclk_q    <= 1'b0;
            win_len_q <= WIN_WIDTH'(1);
            cont_q    <= 1'b0;
        end else begin
            wclk_q    <= wclk_d;
            win_len_q <= win_len_d;
            cont_q    <= cont_d;
        end
    end

    // ---------------------------------------------------------------- window FSM
    state_e               state_q, state_d;
    logic [WIN_WIDTH-1:0] win_cur_q, win_cur_d;
    logic [WIN_WIDTH-1:0] beat_idx_q, beat_idx_d;
    logic [WIN_WIDTH-1:0] len_eff;
    logic                 first_last, acc_last;
    logic                 start, accept, abort;
    logic [WIN_WIDTH-1:0] cur_idx;
    logic                 cur_last;

    assign len_eff    = (win_len_q == '0) ? WIN_WIDTH'(1) : win_len_q;
    assign first_last = (len_eff == WIN_WIDTH'(1));
    assign acc_last   = (beat_idx_q == win_cur_q - WIN_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run && s_axis_tvalid) start = 1'b1;
            end
            StAcc: begin
                if (!run) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (s_axis_tvalid) begin
                    accept = 1'b1;
                    if (acc_last) state_d = StDone;
                end
            end
            StDone: begin
                // Continuous mode reopens straight from here, so there is no dead cycle.
                if (!run) state_d = StIdle;
                else if (cont_q && s_axis_tvalid) start = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            accept  = 1'b1;
            state_d = first_last ? StDone : StAcc;
        end
    end

    always_comb begin
        cur_idx    = start ? '0 : beat_idx_q;
        cur_last   = start ? first_last : acc_last;
        win_cur_d  = start ? len_eff : win_cur_q;
        beat_idx_d = beat_idx_q;
        if (accept) beat_idx_d = cur_idx + WIN_WIDTH'(1);
        if (abort)  beat_idx_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            win_cur_q  <= WIN_WIDTH'(1);
            beat_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            win_cur_q  <= win_cur_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    assign busy          = (state_q == StAcc);
    assign s_axis_tready = 1'b1;

    // ---------------------------------------------------------------- P0: beat capture
    logic                                       p0_valid_q, p0_valid_d;
    logic [DATA_W-1:0]                          p0_data_q, p0_data_d;
    logic [SAMPLES_PER_WORD-1:0][SAMPLE_WIDTH-1:0] p0_mag_q, p0_mag_d;
    logic                                       p0_first_q, p0_first_d;
    logic                                       p0_last_q, p0_last_d;
    logic [WIN_WIDTH-1:0]                       p0_idx_q, p0_idx_d;

    always_comb begin
        p0_valid_d = accept;
        p0_data_d  = p0_data_q;
        p0_mag_d   = p0_mag_q;
        p0_first_d = p0_first_q;
        p0_last_d  = p0_last_q;
        p0_idx_d   = p0_idx_q;
        if (accept) begin
            p0_data_d  = s_axis_tdata;
            p0_first_d = start;
            p0_last_d  = cur_last;
            p0_idx_d   = cur_idx;
            for (int l = 0; l < int'(SAMPLES_PER_WORD); l++) begin
                p0_mag_d[l] = abs_mag(s_axis_tdata[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_valid_q <= 1'b0;
            p0_data_q  <= '0;
            p0_mag_q   <= '0;
            p0_first_q <= 1'b0;
            p0_last_q  <= 1'b0;
            p0_idx_q   <= '0;
        end else begin
            p0_valid_q <= p0_valid_d;
            p0_data_q  <= p0_data_d;
            p0_mag_q   <= p0_mag_d;
            p0_first_q <= p0_first_d;
            p0_last_q  <= p0_last_d;
            p0_idx_q   <= p0_idx_d;
        end
    end

    // ---------------------------------------------------------------- P1: lane max tree
    // Heap layout: node i has children 2i+1 (lower lanes) and 2i+2; leaves start at SPW-1.
    logic [NODES-1:0][SAMPLE_WIDTH-1:0] tree_mag;
    logic [NODES-1:0][SAMPLE_WIDTH-1:0] tree_smp;
    logic [NODES-1:0][LANE_BITS-1:0]    tree_lane;

    always_comb begin
        tree_mag  = '0;
        tree_smp  = '0;
        tree_lane = '0;
        for (int l = 0; l < int'(SAMPLES_PER_WORD); l++) begin
            tree_mag[int'(SAMPLES_PER_WORD) - 1 + l]  = p0_mag_q[l];
            tree_smp[int'(SAMPLES_PER_WORD) - 1 + l]  = p0_data_q[l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            tree_lane[int'(SAMPLES_PER_WORD) - 1 + l] = LANE_BITS'(l);
        end
        for (int i = int'(SAMPLES_PER_WORD) - 2; i >= 0; i--) begin
            if (tree_mag[2*i+2] > tree_mag[2*i+1]) begin
                tree_mag[i]  = tree_mag[2*i+2];
                tree_smp[i]  = tree_smp[2*i+2];
                tree_lane[i] = tree_lane[2*i+2];
            end else begin
                tree_mag[i]  = tree_mag[2*i+1];
                tree_smp[i]  = tree_smp[2*i+1];
                tree_lane[i] = tree_lane[2*i+1];
            end
        end
    end

    logic                    p1_valid_q, p1_valid_d;
    logic [SAMPLE_WIDTH-1:0] p1_mag_q, p1_mag_d;
    logic [SAMPLE_WIDTH-1:0] p1_smp_q, p1_smp_d;
    logic [POS_WIDTH-1:0]    p1_pos_q, p1_pos_d;
    logic                    p1_first_q, p1_first_d;
    logic                    p1_last_q, p1_last_d;

    always_comb begin
        // Partial beats of an aborted window are dropped; a finished window's last beat is kept.
        p1_valid_d = p0_valid_q && !(abort && !p0_last_q);
        p1_mag_d   = p1_mag_q;
        p1_smp_d   = p1_smp_q;
        p1_pos_d   = p1_pos_q;
        p1_first_d = p1_first_q;
        p1_last_d  = p1_last_q;
        if (p0_valid_q) begin
            p1_mag_d   = tree_mag[0];
            p1_smp_d   = tree_smp[0];
            p1_pos_d   = {p0_idx_q, tree_lane[0]};
            p1_first_d = p0_first_q;
            p1_last_d  = p0_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid_q <= 1'b0;
            p1_mag_q   <= '0;
            p1_smp_q   <= '0;
            p1_pos_q   <= '0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_mag_q   <= p1_mag_d;
            p1_smp_q   <= p1_smp_d;
            p1_pos_q   <= p1_pos_d;
            p1_first_q <= p1_first_d;
            p1_last_q  <= p1_last_d;
        end
    end

    // ---------------------------------------------------------------- P2: window accumulate
    logic                    p1_live, take_new;
    logic [SAMPLE_WIDTH-1:0] best_mag, best_smp;
    logic [POS_WIDTH-1:0]    best_pos;
    logic [SAMPLE_WIDTH-1:0] acc_mag_q, acc_mag_d;
    logic [SAMPLE_WIDTH-1:0] acc_smp_q, acc_smp_d;
    logic [POS_WIDTH-1:0]    acc_pos_q, acc_pos_d;
    logic                    peak_valid_q, peak_valid_d;
    logic [SAMPLE_WIDTH-1:0] peak_out_q, peak_out_d;
    logic [SAMPLE_WIDTH-1:0] peak_mag_q, peak_mag_d;
    logic [POS_WIDTH-1:0]    peak_pos_q, peak_pos_d;

    always_comb begin
        p1_live  = p1_valid_q && !(abort && !p1_last_q);
        // Strict compare keeps the earlier beat on a tie.
        take_new = p1_first_q || (p1_mag_q > acc_mag_q);
        best_mag = take_new ? p1_mag_q : acc_mag_q;
        best_smp = take_new ? p1_smp_q : acc_smp_q;
        best_pos = take_new ? p1_pos_q : acc_pos_q;

        acc_mag_d = acc_mag_q;
        acc_smp_d = acc_smp_q;
        acc_pos_d = acc_pos_q;
        if (p1_live) begin
            acc_mag_d = best_mag;
            acc_smp_d = best_smp;
            acc_pos_d = best_pos;
        end

        peak_valid_d = p1_live && p1_last_q;
        peak_out_d   = peak_valid_d ? best_smp : peak_out_q;
        peak_mag_d   = peak_valid_d ? best_mag : peak_mag_q;
        peak_pos_d   = peak_valid_d ? best_pos : peak_pos_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_mag_q    <= '0;
            acc_smp_q    <= '0;
            acc_pos_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_out_q   <= '0;
            peak_mag_q   <= '0;
            peak_pos_q   <= '0;
        end else begin
            acc_mag_q    <= acc_mag_d;
            acc_smp_q    <= acc_smp_d;
            acc_pos_q    <= acc_pos_d;
            peak_valid_q <= peak_valid_d;
            peak_out_q   <= peak_out_d;
            peak_mag_q   <= peak_mag_d;
            peak_pos_q   <= peak_pos_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_out   = peak_out_q;
    assign peak_mag   = peak_mag_q;
    assign peak_pos   = peak_pos_q;

    // ---------------------------------------------------------------- threshold flag
`ifdef PEAK_THRESHOLD_EN
    logic [7:0] thresh_q, thresh_d;
    logic       over_q, over_d;

    always_comb begin
        thresh_d = thresh_q;
        over_d   = over_q;
        if (wr_stb && gpio_addr == 16'(BASE_ADDR + 2)) begin
            thresh_d = gpio_data;
        end
        if (peak_valid_d) begin
            over_d = (best_mag >= {thresh_q, {(SAMPLE_WIDTH-8){1'b0}}});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh_q <= 8'hFF;
            over_q   <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            over_q   <= over_d;
        end
    end

    assign peak_over_thresh = over_q;
`else
    assign peak_over_thresh = 1'b0;
`endif

endmodule
